// File: rtl/common_types.sv
//------------------------------------------------------------------------------
// common_types
//   Shared types and width constants for the dyt memory arbiter slice.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package common_types;

   localparam int C_BEN_W  = 4;
   localparam int C_SIZE_W = 2;
   localparam int C_WORD_W = 32;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } mem_size_t;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_RD1  = 2'd1,
      ARB_RD2  = 2'd2,
      ARB_WR   = 2'd3
   } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/dyt_mem_align.sv
//------------------------------------------------------------------------------
// dyt_mem_align
//   Store lane steering and load lane extraction with sign/zero extension.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dyt_mem_align
   import common_types::*;
(
   input  logic [1:0]          i_addr_lo,
   input  mem_size_t           i_size,
   input  logic                i_unsigned,
   input  logic [C_WORD_W-1:0] i_wdata,
   input  logic [C_WORD_W-1:0] i_rdata,
   output logic [C_BEN_W-1:0]  o_ben,
   output logic [C_WORD_W-1:0] o_wdata,
   output logic [C_WORD_W-1:0] o_rdata
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_rdata[7:0];
      case (i_addr_lo)
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         2'd3:    w_byte = i_rdata[31:24];
         default: w_byte = i_rdata[7:0];
      endcase
      w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

      o_ben   = {C_BEN_W{1'b1}};
      o_wdata = i_wdata;
      o_rdata = i_rdata;
      case (i_size)
         SZ_BYTE: begin
            o_ben   = 4'b0001 << i_addr_lo;
            o_wdata = {4{i_wdata[7:0]}};
            o_rdata = {{24{~i_unsigned & w_byte[7]}}, w_byte};
         end
         SZ_HALF: begin
            o_ben   = 4'b0011 << i_addr_lo;
            o_wdata = {2{i_wdata[15:0]}};
            o_rdata = {{16{~i_unsigned & w_half[15]}}, w_half};
         end
         default: begin
            o_ben   = {C_BEN_W{1'b1}};
            o_wdata = i_wdata;
            o_rdata = i_rdata;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/dyt_mem_arbiter.sv
//------------------------------------------------------------------------------
// dyt_mem_arbiter
//   Instruction/data arbiter in front of a single-port SRAM, one access in flight.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dyt_mem_arbiter
   import common_types::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int D_BURST_MAX = 4
)(
   input  logic                clk,
   input  logic                n_rst,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_gnt,
   output logic [DATA_W-1:0]   i_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [C_SIZE_W-1:0] d_size,
   input  logic                d_unsigned,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic                d_gnt,
   output logic [DATA_W-1:0]   d_rdata,
   output logic [ADDR_W-1:0]   sram_addr,
   output logic                sram_ren,
   output logic                sram_wen,
   output logic [C_BEN_W-1:0]  sram_ben,
   output logic [DATA_W-1:0]   sram_wdata,
   input  logic [DATA_W-1:0]   sram_rdata
);

   localparam int                    C_STREAK_W   = $clog2(D_BURST_MAX + 1);
   localparam logic [C_STREAK_W-1:0] C_STREAK_MAX = C_STREAK_W'(D_BURST_MAX);

   arb_state_t              r_state;
   logic                    r_live;
   logic                    r_own_i;
   logic                    r_last_d;
   logic [C_STREAK_W-1:0]   r_streak;
   logic [ADDR_W-1:0]       r_addr;
   mem_size_t               r_size;
   logic                    r_uns;
   logic [DATA_W-1:0]       r_wdata;

   logic                    w_idle;
   logic                    w_pick_i;
   logic                    w_accept;
   logic                    w_acc_we;
   logic [ADDR_W-1:0]       w_acc_addr;
   logic [1:0]              w_al_lo;
   mem_size_t               w_al_size;
   logic                    w_al_uns;
   logic [DATA_W-1:0]       w_al_wdata;
   logic [C_BEN_W-1:0]      w_ben;
   logic [DATA_W-1:0]       w_st_data;
   logic [DATA_W-1:0]       w_ld_data;

   // r_live blocks acceptance in the first cycle after reset so no command escapes
   assign w_idle     = (r_state == ARB_IDLE);
   assign w_pick_i   = i_req && (!d_req || (r_streak == C_STREAK_MAX) || r_last_d);
   assign w_accept   = r_live && w_idle && (i_req || d_req);
   assign w_acc_we   = !w_pick_i && d_we;
   assign w_acc_addr = w_pick_i ? i_addr : d_addr;

   // In IDLE the live data request drives the lanes; afterwards the captured copy does
   assign w_al_lo    = w_idle ? d_addr[1:0] : r_addr[1:0];
   assign w_al_size  = w_idle ? mem_size_t'(d_size) : r_size;
   assign w_al_uns   = w_idle ? d_unsigned : r_uns;
   assign w_al_wdata = w_idle ? d_wdata : r_wdata;

   dyt_mem_align u_align (
      .i_addr_lo  (w_al_lo),
      .i_size     (w_al_size),
      .i_unsigned (w_al_uns),
      .i_wdata    (w_al_wdata),
      .i_rdata    (sram_rdata),
      .o_ben      (w_ben),
      .o_wdata    (w_st_data),
      .o_rdata    (w_ld_data)
   );

   always_comb begin
      sram_addr  = '0;
      sram_ren   = 1'b0;
      sram_wen   = 1'b0;
      sram_ben   = '0;
      sram_wdata = '0;
      i_gnt      = 1'b0;
      d_gnt      = 1'b0;
      i_rdata    = '0;
      d_rdata    = '0;
      case (r_state)
         ARB_IDLE: begin
            if (w_accept) begin
               sram_addr = {w_acc_addr[ADDR_W-1:2], 2'b00};
               sram_ren  = !w_acc_we;
               sram_wen  = w_acc_we;
               if (w_acc_we) begin
                  sram_ben   = w_ben;
                  sram_wdata = w_st_data;
               end
            end
         end
         ARB_RD1: begin
            sram_addr = {r_addr[ADDR_W-1:2], 2'b00};
            sram_ren  = 1'b1;
         end
         ARB_RD2: begin
            if (r_own_i) begin
               i_gnt   = 1'b1;
               i_rdata = sram_rdata;
            end else begin
               d_gnt   = 1'b1;
               d_rdata = w_ld_data;
            end
         end
         default: begin
            sram_addr  = {r_addr[ADDR_W-1:2], 2'b00};
            sram_wen   = 1'b1;
            sram_ben   = w_ben;
            sram_wdata = w_st_data;
            d_gnt      = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         r_state  <= ARB_IDLE;
         r_live   <= 1'b0;
         r_own_i  <= 1'b0;
         r_last_d <= 1'b0;
         r_streak <= '0;
         r_addr   <= '0;
         r_size   <= SZ_BYTE;
         r_uns    <= 1'b0;
         r_wdata  <= '0;
      end else begin
         r_live <= 1'b1;
         case (r_state)
            ARB_IDLE: begin
               if (w_accept) begin
                  r_own_i <= w_pick_i;
                  r_addr  <= w_acc_addr;
                  r_size  <= mem_size_t'(d_size);
                  r_uns   <= d_unsigned;
                  r_wdata <= d_wdata;
                  r_state <= w_acc_we ? ARB_WR : ARB_RD1;
               end
            end
            ARB_RD1: r_state <= ARB_RD2;
            default: r_state <= ARB_IDLE;
         endcase

         if (i_gnt)
            r_last_d <= 1'b0;
         else if (d_gnt)
            r_last_d <= 1'b1;

         if (!i_req || i_gnt)
            r_streak <= '0;
         else if (d_gnt && (r_streak != C_STREAK_MAX))
            r_streak <= r_streak + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dyt_mem_arbiter.sv
//------------------------------------------------------------------------------
// tb_dyt_mem_arbiter
//   Directed self-checking bench for dyt_mem_arbiter with a 2-cycle SRAM model.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_dyt_mem_arbiter;

   logic        clk;
   logic        n_rst;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [1:0]  d_size;
   logic        d_unsigned;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic [31:0] d_rdata;
   logic [31:0] sram_addr;
   logic        sram_ren;
   logic        sram_wen;
   logic [3:0]  sram_ben;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;

   int n_vec;
   int n_err;

   logic [31:0] mem [0:255];
   logic [31:0] r_p1;
   logic [31:0] r_p2;

   dyt_mem_arbiter #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .D_BURST_MAX (4)
   ) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .i_req      (i_req),
      .i_addr     (i_addr),
      .i_gnt      (i_gnt),
      .i_rdata    (i_rdata),
      .d_req      (d_req),
      .d_we       (d_we),
      .d_size     (d_size),
      .d_unsigned (d_unsigned),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_gnt      (d_gnt),
      .d_rdata    (d_rdata),
      .sram_addr  (sram_addr),
      .sram_ren   (sram_ren),
      .sram_wen   (sram_wen),
      .sram_ben   (sram_ben),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM: read data appears two cycles after the accepting edge; reset preloads
   always @(posedge clk) begin
      if (!n_rst) begin
         mem[8'h10] <= 32'hDEADBEEF;
         mem[8'h40] <= 32'h80011234;
      end else if (sram_wen) begin
         for (int b = 0; b < 4; b++)
            if (sram_ben[b]) mem[sram_addr[9:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
      if (sram_ren) r_p1 <= mem[sram_addr[9:2]];
      r_p2 <= r_p1;
   end
   assign sram_rdata = r_p2;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_d(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
      logic aligned;
      aligned = (size == 2'd0) ? 1'b1 : (size == 2'd1) ? !addr[0] : (addr[1:0] == 2'b00);
      assert (aligned) else begin
         n_err++;
         $error("FAIL d_addr_align observed=%h expected=aligned_to_size_%0d", addr, size);
      end
      d_req = 1'b1; d_we = we; d_size = size; d_unsigned = uns; d_addr = addr; d_wdata = wd;
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      n_rst = 1'b0; i_req = 1'b0; i_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_size = 2'd0; d_unsigned = 1'b0; d_addr = '0; d_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      chk("rst_ren",   {31'd0, sram_ren}, 32'd0);
      chk("rst_wen",   {31'd0, sram_wen}, 32'd0);
      chk("rst_ben",   {28'd0, sram_ben}, 32'd0);
      chk("rst_addr",  sram_addr, 32'd0);
      chk("rst_gnt",   {30'd0, i_gnt, d_gnt}, 32'd0);
      chk("rst_rdata", i_rdata | d_rdata, 32'd0);
      n_rst = 1'b1;

      // signed half load from 0x102 (word 0x80011234)
      @(negedge clk); set_d(1'b0, 2'd1, 1'b0, 32'h102, 32'd0); #1;
      chk("ldh_acc_ren",  {31'd0, sram_ren}, 32'd1);
      chk("ldh_acc_addr", sram_addr, 32'h100);
      @(negedge clk); #1;
      chk("ldh_rd1_ren", {31'd0, sram_ren}, 32'd1);
      chk("ldh_rd1_gnt", {31'd0, d_gnt}, 32'd0);
      chk("ldh_rd1_rd",  d_rdata, 32'd0);
      @(negedge clk); #1;
      chk("ldh_s_gnt",  {31'd0, d_gnt}, 32'd1);
      chk("ldh_s_data", d_rdata, 32'hFFFF8001);
      chk("ldh_rd2_ren", {31'd0, sram_ren}, 32'd0);
      d_req = 1'b0;

      // unsigned half load from 0x102
      @(negedge clk); set_d(1'b0, 2'd1, 1'b1, 32'h102, 32'd0);
      repeat (2) @(negedge clk);
      #1;
      chk("ldh_u_gnt",  {31'd0, d_gnt}, 32'd1);
      chk("ldh_u_data", d_rdata, 32'h00008001);
      d_req = 1'b0;

      // byte store 0xA5 to 0x103
      @(negedge clk); set_d(1'b1, 2'd0, 1'b0, 32'h103, 32'h000000A5); #1;
      chk("stb_acc_wen",  {31'd0, sram_wen}, 32'd1);
      chk("stb_acc_ren",  {31'd0, sram_ren}, 32'd0);
      chk("stb_acc_addr", sram_addr, 32'h100);
      @(negedge clk); #1;
      chk("stb_wr_wen",   {31'd0, sram_wen}, 32'd1);
      chk("stb_wr_addr",  sram_addr, 32'h100);
      chk("stb_wr_ben",   {28'd0, sram_ben}, 32'h8);
      chk("stb_wr_wdata", sram_wdata, 32'hA5A5A5A5);
      chk("stb_wr_gnt",   {31'd0, d_gnt}, 32'd1);
      d_req = 1'b0;

      // byte loads back from 0x103 (word now 0xA5011234)
      @(negedge clk); set_d(1'b0, 2'd0, 1'b1, 32'h103, 32'd0);
      repeat (2) @(negedge clk);
      #1;
      chk("ldb_u_data", d_rdata, 32'h000000A5);
      d_req = 1'b0;
      @(negedge clk); set_d(1'b0, 2'd0, 1'b0, 32'h103, 32'd0);
      repeat (2) @(negedge clk);
      #1;
      chk("ldb_s_data", d_rdata, 32'hFFFFFFA5);
      d_req = 1'b0;

      // lone instruction fetch from 0x40
      @(negedge clk); i_req = 1'b1; i_addr = 32'h40; #1;
      chk("if_acc_ren",  {31'd0, sram_ren}, 32'd1);
      chk("if_acc_addr", sram_addr, 32'h40);
      @(negedge clk); #1;
      chk("if_rd1_gnt", {31'd0, i_gnt}, 32'd0);
      @(negedge clk); #1;
      chk("if_gnt",   {31'd0, i_gnt}, 32'd1);
      chk("if_data",  i_rdata, 32'hDEADBEEF);
      chk("if_dgnt",  {31'd0, d_gnt}, 32'd0);
      i_req = 1'b0;

      // simultaneous requests: data first, instruction in the next IDLE
      @(negedge clk); i_req = 1'b1; i_addr = 32'h40; set_d(1'b0, 2'd2, 1'b0, 32'h100, 32'd0); #1;
      chk("sim_t0_addr", sram_addr, 32'h100);
      chk("sim_t0_excl", {31'd0, sram_ren & sram_wen}, 32'd0);
      @(negedge clk); #1;
      chk("sim_t1_gnt", {30'd0, i_gnt, d_gnt}, 32'd0);
      @(negedge clk); #1;
      chk("sim_t2_gnt",  {30'd0, i_gnt, d_gnt}, 32'd1);
      chk("sim_t2_data", d_rdata, 32'hA5011234);
      d_req = 1'b0;
      @(negedge clk); #1;
      chk("sim_t3_addr", sram_addr, 32'h40);
      chk("sim_t3_ren",  {31'd0, sram_ren}, 32'd1);
      chk("sim_t3_excl", {31'd0, sram_ren & sram_wen}, 32'd0);
      @(negedge clk); #1;
      chk("sim_t4_gnt", {30'd0, i_gnt, d_gnt}, 32'd0);
      @(negedge clk); #1;
      chk("sim_t5_gnt",  {30'd0, i_gnt, d_gnt}, 32'd2);
      chk("sim_t5_data", i_rdata, 32'hDEADBEEF);
      i_req = 1'b0;

      // both held continuously: grants alternate data, instruction, data, instruction
      @(negedge clk); i_req = 1'b1; i_addr = 32'h40; set_d(1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
      for (int c = 0; c < 12; c++) begin
         if (c != 0) @(negedge clk);
         #1;
         chk($sformatf("burst_d%0d", c), {31'd0, d_gnt}, {31'd0, (c == 2) || (c == 8)});
         chk($sformatf("burst_i%0d", c), {31'd0, i_gnt}, {31'd0, (c == 5) || (c == 11)});
      end
      i_req = 1'b0; d_req = 1'b0;

      // reset during RD1 abandons the access
      @(negedge clk); set_d(1'b0, 2'd2, 1'b0, 32'h100, 32'd0); #1;
      chk("rrd_acc_ren", {31'd0, sram_ren}, 32'd1);
      @(negedge clk); #1;
      chk("rrd_rd1_ren", {31'd0, sram_ren}, 32'd1);
      n_rst = 1'b0;
      @(negedge clk); #1;
      chk("rrd_gnt", {30'd0, i_gnt, d_gnt}, 32'd0);
      chk("rrd_cmd", {30'd0, sram_ren, sram_wen}, 32'd0);
      chk("rrd_rd",  d_rdata, 32'd0);
      n_rst = 1'b1; d_req = 1'b0;
      @(negedge clk); i_req = 1'b1; i_addr = 32'h40; #1;
      chk("rrd_idle_ren",  {31'd0, sram_ren}, 32'd1);
      chk("rrd_idle_addr", sram_addr, 32'h40);
      repeat (2) @(negedge clk);
      #1;
      chk("rrd_if_gnt",  {31'd0, i_gnt}, 32'd1);
      chk("rrd_if_data", i_rdata, 32'hDEADBEEF);
      i_req = 1'b0;

      @(negedge clk); #1;
      chk("end_idle", {28'd0, sram_ren, sram_wen, i_gnt, d_gnt}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
